// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte stream and writes it word by word into program memory.
// Latency: one WRITE cycle per assembled word. DONE is registered on the cycle after the last word, or after the check byte.
// Backpressure: byte_ready_o is low in IDLE, WRITE and DONE. With no byte_valid_i the FSM stalls indefinitely (no timeout).
//
// Ports
//   clk, reset (async active-low)          system clock and reset
//   start_i                                 begins a load from IDLE or DONE
//   byte_data_i / byte_valid_i / byte_ready_o   incoming stream handshake
//   mem_write_o / mem_address_o / mem_data_o    program memory write port
//   cpu_reset_o                             processor reset, active-low, released only in DONE
//   done_o, error_o                         load complete / sticky error (overflow or bad checksum)
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to add a trailing XOR check byte (CHECK state).

module program_loader #(
   parameter int MEMORY_DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [7:0]  byte_data_i,
   input  logic        byte_valid_i,
   output logic        byte_ready_o,
   output logic        mem_write_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_data_o,
   output logic        cpu_reset_o,
   output logic        done_o,
   output logic        error_o
);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      , CHECK
`endif
   } state_t;

   // State entered once every word of the load has been handled.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam state_t END_STATE = CHECK;
`else
   localparam state_t END_STATE = DONE;
`endif
   localparam logic END_IS_DONE = (END_STATE == DONE);

   state_t      state;
   logic [15:0] word_count;
   logic [29:0] word_index;
   logic [1:0]  byte_index;
   logic [23:0] shift_word;   // first three bytes of the word in flight

   logic        take;
   logic [31:0] idx_ext;
   logic [31:0] idx_next;
   logic        in_range;
   logic        last_word;

   assign take      = byte_valid_i & byte_ready_o;
   assign idx_ext   = {2'b00, word_index};
   assign idx_next  = idx_ext + 32'd1;
   assign in_range  = idx_ext < 32'(MEMORY_DEPTH);
   assign last_word = idx_next >= {16'd0, word_count};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   // Running XOR of every byte consumed before the check byte.
   logic [7:0] checksum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         checksum <= 8'd0;
      end else if ((state == IDLE || state == DONE) && start_i) begin
         checksum <= 8'd0;
      end else if (take && (state == LEN_HI || state == LEN_LO || state == DATA)) begin
         checksum <= checksum ^ byte_data_i;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         word_count    <= 16'd0;
         word_index    <= 30'd0;
         byte_index    <= 2'd0;
         shift_word    <= 24'd0;
         byte_ready_o  <= 1'b0;
         mem_write_o   <= 1'b0;
         mem_address_o <= 32'd0;
         mem_data_o    <= 32'd0;
         cpu_reset_o   <= 1'b0;
         done_o        <= 1'b0;
         error_o       <= 1'b0;
      end else begin
         mem_write_o <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  state        <= LEN_HI;
                  byte_ready_o <= 1'b1;
                  done_o       <= 1'b0;
                  error_o      <= 1'b0;
                  cpu_reset_o  <= 1'b0;
                  word_index   <= 30'd0;
                  byte_index   <= 2'd0;
               end
            end
            LEN_HI: begin
               if (take) begin
                  word_count[15:8] <= byte_data_i;
                  state            <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (take) begin
                  word_count[7:0] <= byte_data_i;
                  if ({word_count[15:8], byte_data_i} == 16'd0) begin
                     // Empty program: skip straight past the data phase.
                     state        <= END_STATE;
                     byte_ready_o <= !END_IS_DONE;
                     done_o       <= END_IS_DONE;
                     cpu_reset_o  <= END_IS_DONE;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (take) begin
                  byte_index <= byte_index + 2'd1;
                  shift_word <= {shift_word[15:0], byte_data_i};
                  if (byte_index == 2'd3) begin
                     // Present the word during WRITE; words past capacity are dropped and flagged.
                     state         <= WRITE;
                     byte_ready_o  <= 1'b0;
                     mem_address_o <= {word_index, 2'b00};
                     mem_data_o    <= {shift_word, byte_data_i};
                     mem_write_o   <= in_range;
                     if (!in_range) begin
                        error_o <= 1'b1;
                     end
                  end
               end
            end
            WRITE: begin
               word_index <= word_index + 30'd1;
               if (last_word) begin
                  state        <= END_STATE;
                  byte_ready_o <= !END_IS_DONE;
                  done_o       <= END_IS_DONE;
                  cpu_reset_o  <= END_IS_DONE;
               end else begin
                  state        <= DATA;
                  byte_ready_o <= 1'b1;
               end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
               if (take) begin
                  if (byte_data_i != checksum) begin
                     error_o <= 1'b1;
                  end
                  state        <= DONE;
                  byte_ready_o <= 1'b0;
                  done_o       <= 1'b1;
                  cpu_reset_o  <= 1'b1;
               end
            end
`endif
            default: begin
               state        <= IDLE;
               byte_ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed loads against a queue-based reference model.
// Expected memory writes are queued when a load is issued; a negedge monitor pops and compares each write.
// Builds with or without PROGRAM_LOADER_CHECKSUM_EN.

module tb_program_loader;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_i = 1'b0;
   logic [7:0]  byte_data_i = 8'd0;
   logic        byte_valid_i = 1'b0;
   logic        byte_ready_o;
   logic        mem_write_o;
   logic [31:0] mem_address_o;
   logic [31:0] mem_data_o;
   logic        cpu_reset_o;
   logic        done_o;
   logic        error_o;

   always #5 clk = ~clk;

   program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start_i),
      .byte_data_i  (byte_data_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .mem_write_o  (mem_write_o),
      .mem_address_o(mem_address_o),
      .mem_data_o   (mem_data_o),
      .cpu_reset_o  (cpu_reset_o),
      .done_o       (done_o),
      .error_o      (error_o)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] prog_q[$];
   wr_t         mon_e;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every write strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (reset === 1'b1 && mem_write_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_address_o, mem_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", mem_address_o, mon_e.addr);
            check("write_data", mem_data_o, mon_e.data);
            check("ready_low_in_write", {31'd0, byte_ready_o}, 32'd0);
         end
      end
   end

   // Offer one byte; returns at the negedge after the edge that consumed it.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int waitc = 0;
      if (gap) begin
         byte_valid_i = 1'b0;
         byte_data_i  = 8'($urandom_range(0, 255));
         start_i      = 1'($urandom_range(0, 1));   // must be ignored mid-load
         repeat ($urandom_range(1, 3)) @(negedge clk);
         start_i = 1'b0;
      end
      byte_data_i  = b;
      byte_valid_i = 1'b1;
      while (byte_ready_o !== 1'b1 && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (waitc >= 20) begin
         vectors++;
         miscompares++;
         $display("FAIL byte_accept_timeout: got ready %b, expected 1 within 20 cycles", byte_ready_o);
      end
      @(negedge clk);
   endtask

   // Load prog_q. cks_mode: 0 correct checksum, 1 random wrong checksum, 2 checksum byte 0x00.
   task automatic run_load(input int cks_mode, input bit gaps);
      int         n = prog_q.size();
      logic [15:0] n16 = 16'(n);
      logic [7:0] x = 8'd0;
      logic [7:0] cks;
      bit         exp_err = 1'b0;
      int         waitc = 0;
      for (int i = 0; i < n; i++) begin
         if (i < DEPTH) exp_q.push_back({32'(i * 4), prog_q[i]});
         else exp_err = 1'b1;
      end
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("cpu_reset_low_loading", {31'd0, cpu_reset_o}, 32'd0);
      check("done_cleared", {31'd0, done_o}, 32'd0);
      send_byte(n16[15:8], gaps);
      x ^= n16[15:8];
      send_byte(n16[7:0], gaps);
      x ^= n16[7:0];
      for (int i = 0; i < n; i++) begin
         for (int b = 3; b >= 0; b--) begin
            send_byte(prog_q[i][8*b +: 8], gaps);
            x ^= prog_q[i][8*b +: 8];
         end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (cks_mode == 2) cks = 8'h00;
      else if (cks_mode == 1) cks = x ^ 8'($urandom_range(1, 255));
      else cks = x;
      if (cks != x) exp_err = 1'b1;
      send_byte(cks, gaps);
`else
      cks = 8'(cks_mode);
`endif
      byte_valid_i = 1'b0;
      while (done_o !== 1'b1 && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      check("done", {31'd0, done_o}, 32'd1);
      check("cpu_reset_released", {31'd0, cpu_reset_o}, 32'd1);
      check("error", {31'd0, error_o}, {31'd0, exp_err});
      check("ready_in_done", {31'd0, byte_ready_o}, 32'd0);
      check("writes_outstanding", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      // Reset state.
      #12;
      check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
      check("rst_write", {31'd0, mem_write_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_error", {31'd0, error_o}, 32'd0);
      check("rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
      check("rst_addr", mem_address_o, 32'd0);
      check("rst_data", mem_data_o, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Single word DEADBEEF.
      prog_q = '{32'hDEADBEEF};
      run_load(0, 1'b0);

      // Empty program.
      prog_q.delete();
      run_load(0, 1'b1);

      // Three words with valid held high across WRITE.
      prog_q = '{32'h11223344, 32'hA5A55A5A, 32'h0BADF00D};
      run_load(0, 1'b0);

      // Overflow: five words into four-word memory.
      prog_q = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'hFFFFFFFF};
      run_load(0, 1'b1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Wrong checksum 0x00 on the DEADBEEF stream.
      prog_q = '{32'hDEADBEEF};
      run_load(2, 1'b0);
`endif

      // Reset mid-load after two data bytes: abort, then reload.
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      byte_valid_i = 1'b0;
      reset = 1'b0;
      #1;
      check("abort_ready", {31'd0, byte_ready_o}, 32'd0);
      check("abort_write", {31'd0, mem_write_o}, 32'd0);
      check("abort_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
      check("abort_done", {31'd0, done_o}, 32'd0);
      check("abort_addr", mem_address_o, 32'd0);
      check("abort_data", mem_data_o, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_waits_start", {31'd0, byte_ready_o}, 32'd0);
      prog_q = '{32'hCAFEBABE, 32'h13579BDF};
      run_load(0, 1'b0);

      // Randomized loads.
      for (int t = 0; t < 20; t++) begin
         prog_q.delete();
         for (int i = 0; i < int'($urandom_range(0, 6)); i++) prog_q.push_back($urandom);
         run_load(($urandom_range(0, 3) == 0) ? 1 : 0, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
